// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG USER data-register bridge.
// Optional build macro JTAG_USER_DR_PARITY_EN adds a parity bit to the scan register.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_WRITE      = 2'b01,
        OP_READ       = 2'b10,
        OP_WRITE_READ = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } sys_state_e;

    localparam logic [3:0] USER_IR_CODE = 4'h4;

    // Scan register field layout: data at the bottom, op above it, optional parity on top.
    localparam int DATA_LSB = 0;
    localparam int OP_W     = 2;
`ifdef JTAG_USER_DR_PARITY_EN
    localparam int PAR_W    = 1;
`else
    localparam int PAR_W    = 0;
`endif

    function automatic logic op_writes(op_e op);
        return (op == OP_WRITE) || (op == OP_WRITE_READ);
    endfunction

    function automatic logic op_reads(op_e op);
        return (op == OP_READ) || (op == OP_WRITE_READ);
    endfunction

endpackage

// File: rtl/jtag_user_dr_bridge_if.sv
// System-side bus of the USER DR bridge: counter read value, preload strobe and debug view.
interface jtag_user_dr_bridge_if #(
    parameter int DATA_W = 4
);
    import jtag_pkg::*;

    // wr_valid is a one-cycle strobe with no ready: the counter always accepts a preload,
    // and wr_data stays stable from the strobe until the next write.
    logic [DATA_W-1:0] rd_value;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    sys_state_e        dbg_state;
    logic              dbg_busy;

    modport master (
        input  rd_value,
        output wr_valid,
        output wr_data,
        output dbg_state,
        output dbg_busy
    );

    modport slave (
        output rd_value,
        input  wr_valid,
        input  wr_data,
        input  dbg_state,
        input  dbg_busy
    );

endinterface

// File: rtl/jtag_cdc_sync.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module jtag_cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_user_dr_bridge.sv
// USER test-data register bridging scanned read/write commands into the sys_clk domain.
// Build macro JTAG_USER_DR_PARITY_EN adds even parity on shift-in and a sticky perr flag.
module jtag_user_dr_bridge
    import jtag_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic tck,
    input  logic tap_reset_n,
    input  logic sys_clk,
    input  logic select_user,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    input  logic tdi,
    output logic tdo,
    jtag_user_dr_bridge_if.master bus
);

    localparam int SR_W   = DATA_W + OP_W + PAR_W;
    localparam int OP_LSB = DATA_LSB + DATA_W;

    // ---------------- tck domain ----------------
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              req_tgl_q, req_tgl_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic              ack_sync;
    logic              busy;
    logic              par_ok;
    op_e               sr_op;
    logic [DATA_W-1:0] sr_data;
    logic [SR_W-1:0]   cap_word;

    // ---------------- sys_clk domain ----------------
    logic              sys_rst_n;
    logic              req_sync;
    logic              req_seen_q;
    logic              ack_tgl_q;
    sys_state_e        state_q;
    logic [DATA_W-1:0] snap_q;
    logic              wr_valid_q;
    logic [DATA_W-1:0] wr_data_q;

    assign sr_op   = op_e'(sr_q[OP_LSB +: OP_W]);
    assign sr_data = sr_q[DATA_LSB +: DATA_W];
    assign busy    = req_tgl_q ^ ack_sync;

`ifdef JTAG_USER_DR_PARITY_EN
    logic perr_q, perr_d;

    // Parity bit makes the whole shifted-in word XOR to zero.
    assign par_ok   = ~(^sr_q);
    assign cap_word = {perr_q, overrun_q, busy, snap_q};
`else
    assign par_ok   = 1'b1;
    assign cap_word = {overrun_q, busy, snap_q};
`endif

    always_comb begin
        sr_d      = sr_q;
        req_tgl_d = req_tgl_q;
        op_d      = op_q;
        data_d    = data_q;
        overrun_d = overrun_q;
`ifdef JTAG_USER_DR_PARITY_EN
        perr_d    = perr_q;
`endif
        if (select_user) begin
            if (capture_dr) begin
                sr_d      = cap_word;
                overrun_d = 1'b0;
`ifdef JTAG_USER_DR_PARITY_EN
                perr_d    = 1'b0;
`endif
            end else if (shift_dr) begin
                sr_d = {tdi, sr_q[SR_W-1:1]};
            end
            // Evaluated after the capture clear so a fresh overrun on the same edge is kept.
            if (update_dr && par_ok && (sr_op != OP_NOP)) begin
                if (busy) begin
                    overrun_d = 1'b1;
                end else begin
                    op_d      = sr_op;
                    data_d    = sr_data;
                    req_tgl_d = ~req_tgl_q;
                end
            end
`ifdef JTAG_USER_DR_PARITY_EN
            if (update_dr && !par_ok) begin
                perr_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge tck or negedge tap_reset_n) begin
        if (!tap_reset_n) begin
            sr_q      <= '0;
            req_tgl_q <= 1'b0;
            op_q      <= OP_NOP;
            data_q    <= '0;
            overrun_q <= 1'b0;
`ifdef JTAG_USER_DR_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sr_q      <= sr_d;
            req_tgl_q <= req_tgl_d;
            op_q      <= op_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
`ifdef JTAG_USER_DR_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign tdo = sr_q[0];

    jtag_cdc_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i  (tck),
        .rst_ni (tap_reset_n),
        .d_i    (ack_tgl_q),
        .q_o    (ack_sync)
    );

    // sys reset asserts asynchronously and releases only after SYNC_STAGES sys_clk edges.
    jtag_cdc_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk_i  (sys_clk),
        .rst_ni (tap_reset_n),
        .d_i    (1'b1),
        .q_o    (sys_rst_n)
    );

    jtag_cdc_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (req_tgl_q),
        .q_o    (req_sync)
    );

    // op_q/data_q are frozen while busy, so they are read here without synchronisation.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            req_seen_q <= 1'b0;
            ack_tgl_q  <= 1'b0;
            snap_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_sync != req_seen_q) begin
                        req_seen_q <= req_sync;
                        state_q    <= ST_EXEC;
                        if (op_writes(op_q)) begin
                            wr_valid_q <= 1'b1;
                            wr_data_q  <= data_q;
                        end
                        if (op_reads(op_q)) begin
                            snap_q <= bus.rd_value;
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    ack_tgl_q <= ~ack_tgl_q;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_busy  = busy;

endmodule
